// File: rtl/sdram_cmd_sequencer.sv
// SDRAM command issuer: takes one abstract command per cycle over valid/ready,
// holds it back until bank/global timing allows it, and drives registered pins.
// Timing is tracked with saturating down-counters loaded with (T-1) on accept.
//
// state     | meaning
// ST_ACTIVE | normal operation, commands gated by bank state and counters
// ST_LOWPWR | self-refresh / power-down, only REC is accepted
module sdram_cmd_sequencer #(
    parameter int ROW_W  = 12,
    parameter int COL_W  = 8,
    parameter int BANK_W = 2,
    parameter int DQM_W  = 4,
    parameter int T_RCD  = 2,
    parameter int T_RP   = 2,
    parameter int T_RC   = 7,
    parameter int T_WR   = 2,
    parameter int T_MRD  = 2,
    parameter int T_RFC  = 7
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic                            cmd_valid,
    output logic                            cmd_ready,
    input  logic [3:0]                      cmd,
    input  logic [BANK_W+ROW_W+COL_W-1:0]   addr_in,
    input  logic [ROW_W-1:0]                mrs,
    input  logic [DQM_W-1:0]                dqm_in,
    output logic                            cke,
    output logic                            cs_n,
    output logic                            ras_n,
    output logic                            cas_n,
    output logic                            we_n,
    output logic [BANK_W-1:0]               ba,
    output logic [ROW_W-1:0]                addr,
    output logic [DQM_W-1:0]                dqm,
    output logic [(2**BANK_W)-1:0]          bank_open,
    output logic                            cmd_err
);
    localparam int NB = 2 ** BANK_W;
    localparam int CW = 5;

    // Command codes 1 and 15 (NOP) need no decode: they fall to the defaults.
    localparam logic [3:0] C_DESL  = 4'd0;
    localparam logic [3:0] C_MRS   = 4'd2;
    localparam logic [3:0] C_ACT   = 4'd3;
    localparam logic [3:0] C_READ  = 4'd4;
    localparam logic [3:0] C_READA = 4'd5;
    localparam logic [3:0] C_WRIT  = 4'd6;
    localparam logic [3:0] C_WRITA = 4'd7;
    localparam logic [3:0] C_PRE   = 4'd8;
    localparam logic [3:0] C_PALL  = 4'd9;
    localparam logic [3:0] C_BST   = 4'd10;
    localparam logic [3:0] C_REF   = 4'd11;
    localparam logic [3:0] C_SELF  = 4'd12;
    localparam logic [3:0] C_SUP   = 4'd13;
    localparam logic [3:0] C_REC   = 4'd14;

    localparam logic [CW-1:0] LD_RCD = CW'(T_RCD - 1);
    localparam logic [CW-1:0] LD_RP  = CW'(T_RP - 1);
    localparam logic [CW-1:0] LD_RC  = CW'(T_RC - 1);
    localparam logic [CW-1:0] LD_WR  = CW'(T_WR - 1);
    localparam logic [CW-1:0] LD_WRP = CW'(T_WR + T_RP - 1);
    localparam logic [CW-1:0] LD_MRD = CW'(T_MRD - 1);
    localparam logic [CW-1:0] LD_RFC = CW'(T_RFC - 1);

    typedef enum logic {ST_ACTIVE, ST_LOWPWR} state_t;
    state_t state_q, state_d;

    logic [CW-1:0] rcd_q [NB];
    logic [CW-1:0] rp_q  [NB];
    logic [CW-1:0] rc_q  [NB];
    logic [CW-1:0] wr_q  [NB];
    logic [CW-1:0] g_q;
    logic [NB-1:0] open_q;

    logic [BANK_W-1:0] bank;
    logic [ROW_W-1:0]  row;
    logic [ROW_W-1:0]  col_addr;
    logic g_idle, all_rp0, all_wr0, illegal, accept;
    logic [3:0] pin_d;
    logic cke_d, err_d;
    logic [BANK_W-1:0] ba_d;
    logic [ROW_W-1:0]  addr_d;
    logic [DQM_W-1:0]  dqm_d;

    assign bank      = addr_in[COL_W+ROW_W +: BANK_W];
    assign row       = addr_in[COL_W +: ROW_W];
    assign col_addr  = ROW_W'(addr_in[COL_W-1:0]);
    assign bank_open = open_q;
    assign accept    = cmd_valid && cmd_ready;

    // Readiness of the presented command against bank state and counters
    always_comb begin
        all_rp0   = 1'b1;
        all_wr0   = 1'b1;
        illegal   = 1'b0;
        cmd_ready = 1'b0;
        g_idle    = (g_q == '0);
        for (int i = 0; i < NB; i++) begin
            if (rp_q[i] != '0) all_rp0 = 1'b0;
            if (wr_q[i] != '0) all_wr0 = 1'b0;
        end
        case (cmd)
            C_ACT: begin
                illegal   = open_q[bank];
                cmd_ready = g_idle && (rp_q[bank] == '0) && (rc_q[bank] == '0);
            end
            C_READ, C_READA, C_WRIT, C_WRITA: begin
                illegal   = !open_q[bank];
                cmd_ready = g_idle && (rcd_q[bank] == '0);
            end
            C_PRE:               cmd_ready = g_idle && (wr_q[bank] == '0);
            C_PALL:              cmd_ready = g_idle && all_wr0;
            C_MRS, C_REF, C_SELF: cmd_ready = g_idle && (open_q == '0) && all_rp0;
            default:             cmd_ready = 1'b1;
        endcase
        // Illegal commands are swallowed as soon as no global wait is pending.
        if (illegal) cmd_ready = g_idle;
        if (state_q == ST_LOWPWR) cmd_ready = (cmd == C_REC);
        if (!rst_n) cmd_ready = 1'b0;
    end

    // Next power state and next pin values for the accepted command
    always_comb begin
        state_d = state_q;
        pin_d   = 4'b0111;
        cke_d   = cke;
        err_d   = 1'b0;
        ba_d    = '0;
        addr_d  = '0;
        dqm_d   = '1;
        if (accept) begin
            if (state_q == ST_LOWPWR) begin
                state_d = ST_ACTIVE;
                cke_d   = 1'b1;
            end else if (illegal) begin
                err_d = 1'b1;
            end else begin
                case (cmd)
                    C_DESL: pin_d = 4'b1111;
                    C_MRS: begin
                        pin_d  = 4'b0000;
                        addr_d = mrs;
                    end
                    C_ACT: begin
                        pin_d  = 4'b0011;
                        ba_d   = bank;
                        addr_d = row;
                    end
                    C_READ, C_READA: begin
                        pin_d      = 4'b0101;
                        ba_d       = bank;
                        addr_d     = col_addr;
                        addr_d[10] = (cmd == C_READA);
                        dqm_d      = dqm_in;
                    end
                    C_WRIT, C_WRITA: begin
                        pin_d      = 4'b0100;
                        ba_d       = bank;
                        addr_d     = col_addr;
                        addr_d[10] = (cmd == C_WRITA);
                        dqm_d      = dqm_in;
                    end
                    C_PRE: begin
                        pin_d = 4'b0010;
                        ba_d  = bank;
                    end
                    C_PALL: begin
                        pin_d      = 4'b0010;
                        addr_d[10] = 1'b1;
                    end
                    C_BST: pin_d = 4'b0110;
                    C_REF: pin_d = 4'b0001;
                    C_SELF: begin
                        pin_d   = 4'b0001;
                        cke_d   = 1'b0;
                        state_d = ST_LOWPWR;
                    end
                    C_SUP: begin
                        cke_d   = 1'b0;
                        state_d = ST_LOWPWR;
                    end
                    default: ;
                endcase
            end
        end
    end

    // Registered pins and power state
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q                   <= ST_ACTIVE;
            cke                       <= 1'b1;
            {cs_n, ras_n, cas_n, we_n} <= 4'b1111;
            ba                        <= '0;
            addr                      <= '0;
            dqm                       <= '1;
            cmd_err                   <= 1'b0;
        end else begin
            state_q                   <= state_d;
            cke                       <= cke_d;
            {cs_n, ras_n, cas_n, we_n} <= pin_d;
            ba                        <= ba_d;
            addr                      <= addr_d;
            dqm                       <= dqm_d;
            cmd_err                   <= err_d;
        end
    end

    // Timing counters and per-bank open state
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            g_q    <= '0;
            open_q <= '0;
            for (int i = 0; i < NB; i++) begin
                rcd_q[i] <= '0;
                rp_q[i]  <= '0;
                rc_q[i]  <= '0;
                wr_q[i]  <= '0;
            end
        end else begin
            if (g_q != '0) g_q <= g_q - CW'(1);
            for (int i = 0; i < NB; i++) begin
                if (rcd_q[i] != '0) rcd_q[i] <= rcd_q[i] - CW'(1);
                if (rp_q[i]  != '0) rp_q[i]  <= rp_q[i]  - CW'(1);
                if (rc_q[i]  != '0) rc_q[i]  <= rc_q[i]  - CW'(1);
                if (wr_q[i]  != '0) wr_q[i]  <= wr_q[i]  - CW'(1);
            end
            if (accept && state_q == ST_LOWPWR) begin
                g_q <= LD_RC;
            end else if (accept && !illegal) begin
                case (cmd)
                    C_ACT: begin
                        rcd_q[bank]  <= LD_RCD;
                        rc_q[bank]   <= LD_RC;
                        open_q[bank] <= 1'b1;
                    end
                    C_WRIT: wr_q[bank] <= LD_WR;
                    C_PRE, C_READA: begin
                        rp_q[bank]   <= LD_RP;
                        open_q[bank] <= 1'b0;
                    end
                    C_WRITA: begin
                        rp_q[bank]   <= LD_WRP;
                        open_q[bank] <= 1'b0;
                    end
                    C_PALL: begin
                        for (int i = 0; i < NB; i++) rp_q[i] <= LD_RP;
                        open_q <= '0;
                    end
                    C_MRS:   g_q <= LD_MRD;
                    C_REF:   g_q <= LD_RFC;
                    default: ;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_sdram_cmd_sequencer.sv
// Bench for sdram_cmd_sequencer: directed scenarios followed by random traffic,
// every cycle compared against a timestamp-based model of the command rules.
module tb_sdram_cmd_sequencer;
    localparam int ROW_W = 12, COL_W = 8, BANK_W = 2, DQM_W = 4, NB = 4;
    localparam int T_RCD = 2, T_RP = 2, T_RC = 7, T_WR = 2, T_MRD = 2, T_RFC = 7;

    localparam logic [3:0] C_DESL = 0, C_MRS = 2, C_ACT = 3, C_READ = 4, C_READA = 5,
                           C_WRIT = 6, C_WRITA = 7, C_PRE = 8, C_PALL = 9, C_BST = 10,
                           C_REF = 11, C_SELF = 12, C_SUP = 13, C_REC = 14;

    logic clk, rst_n, cmd_valid, cmd_ready;
    logic [3:0] cmd;
    logic [BANK_W+ROW_W+COL_W-1:0] addr_in;
    logic [ROW_W-1:0] mrs;
    logic [DQM_W-1:0] dqm_in;
    logic cke, cs_n, ras_n, cas_n, we_n, cmd_err;
    logic [BANK_W-1:0] ba;
    logic [ROW_W-1:0] addr;
    logic [DQM_W-1:0] dqm;
    logic [NB-1:0] bank_open;

    sdram_cmd_sequencer #(
        .ROW_W(ROW_W), .COL_W(COL_W), .BANK_W(BANK_W), .DQM_W(DQM_W),
        .T_RCD(T_RCD), .T_RP(T_RP), .T_RC(T_RC), .T_WR(T_WR), .T_MRD(T_MRD), .T_RFC(T_RFC)
    ) dut (
        .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd(cmd), .addr_in(addr_in), .mrs(mrs), .dqm_in(dqm_in),
        .cke(cke), .cs_n(cs_n), .ras_n(ras_n), .cas_n(cas_n), .we_n(we_n),
        .ba(ba), .addr(addr), .dqm(dqm), .bank_open(bank_open), .cmd_err(cmd_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    // Reference model: each rule is an "earliest edge" timestamp.
    int e;
    bit m_open [NB];
    int rcd_t [NB], rp_t [NB], rc_t [NB], wr_t [NB];
    int g_t;
    bit m_lp, m_cke;
    logic [4:0] x_pins;
    logic [1:0] x_ba;
    logic [11:0] x_addr;
    logic [3:0] x_dqm;
    logic x_err;
    logic obs_rdy;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [3:0] pack_open();
        logic [3:0] v;
        for (int i = 0; i < NB; i++) v[i] = m_open[i];
        return v;
    endfunction

    task automatic m_reset();
        for (int i = 0; i < NB; i++) begin
            m_open[i] = 0; rcd_t[i] = 0; rp_t[i] = 0; rc_t[i] = 0; wr_t[i] = 0;
        end
        g_t = 0; m_lp = 0; m_cke = 1;
        x_pins = 5'b11111; x_ba = 0; x_addr = 0; x_dqm = 4'hF; x_err = 0;
    endtask

    function automatic bit m_ready();
        int k = e + 1;
        int b = int'(addr_in[21:20]);
        bit ok = (k >= g_t);
        bit r;
        if (!rst_n) return 0;
        if (m_lp) return cmd == C_REC;
        case (cmd)
            C_ACT: r = m_open[b] ? ok : (ok && k >= rp_t[b] && k >= rc_t[b]);
            C_READ, C_READA, C_WRIT, C_WRITA: r = !m_open[b] ? ok : (ok && k >= rcd_t[b]);
            C_PRE: r = ok && k >= wr_t[b];
            C_PALL: begin
                r = ok;
                for (int i = 0; i < NB; i++) if (k < wr_t[i]) r = 0;
            end
            C_MRS, C_REF, C_SELF: begin
                r = ok;
                for (int i = 0; i < NB; i++) if (m_open[i] || k < rp_t[i]) r = 0;
            end
            default: r = 1;
        endcase
        return r;
    endfunction

    task automatic m_update(input bit acc);
        int b = int'(addr_in[21:20]);
        logic [3:0] p = 4'b0111;
        if (!rst_n) begin
            m_reset();
            return;
        end
        x_err = 0; x_ba = 0; x_addr = 0; x_dqm = 4'hF;
        if (acc && m_lp) begin
            m_lp = 0; m_cke = 1; g_t = e + T_RC;
        end else if (acc && ((cmd == C_ACT && m_open[b]) ||
                 (cmd inside {C_READ, C_READA, C_WRIT, C_WRITA} && !m_open[b]))) begin
            x_err = 1;
        end else if (acc) begin
            case (cmd)
                C_DESL: p = 4'b1111;
                C_MRS: begin p = 4'b0000; x_addr = mrs; g_t = e + T_MRD; end
                C_ACT: begin
                    p = 4'b0011; x_ba = 2'(b); x_addr = addr_in[19:8];
                    rcd_t[b] = e + T_RCD; rc_t[b] = e + T_RC; m_open[b] = 1;
                end
                C_READ, C_READA, C_WRIT, C_WRITA: begin
                    p = (cmd inside {C_READ, C_READA}) ? 4'b0101 : 4'b0100;
                    x_ba = 2'(b); x_dqm = dqm_in;
                    x_addr = {4'h0, addr_in[7:0]} | ((cmd inside {C_READA, C_WRITA}) ? 12'h400 : 12'h000);
                    if (cmd == C_WRIT) wr_t[b] = e + T_WR;
                    if (cmd == C_READA) begin rp_t[b] = e + T_RP; m_open[b] = 0; end
                    if (cmd == C_WRITA) begin rp_t[b] = e + T_WR + T_RP; m_open[b] = 0; end
                end
                C_PRE: begin p = 4'b0010; x_ba = 2'(b); rp_t[b] = e + T_RP; m_open[b] = 0; end
                C_PALL: begin
                    p = 4'b0010; x_addr = 12'h400;
                    for (int i = 0; i < NB; i++) begin rp_t[i] = e + T_RP; m_open[i] = 0; end
                end
                C_BST: p = 4'b0110;
                C_REF: begin p = 4'b0001; g_t = e + T_RFC; end
                C_SELF: begin p = 4'b0001; m_cke = 0; m_lp = 1; end
                C_SUP: begin m_cke = 0; m_lp = 1; end
                default: ;
            endcase
        end
        x_pins = {m_cke, p};
    endtask

    task automatic step(output bit acc);
        bit r;
        #1;
        r = m_ready();
        obs_rdy = cmd_ready;
        chk("cmd_ready", 32'(cmd_ready), 32'(r));
        chk("pins", 32'({cke, cs_n, ras_n, cas_n, we_n}), 32'(x_pins));
        chk("ba", 32'(ba), 32'(x_ba));
        chk("addr", 32'(addr), 32'(x_addr));
        chk("dqm", 32'(dqm), 32'(x_dqm));
        chk("bank_open", 32'(bank_open), 32'(pack_open()));
        chk("cmd_err", 32'(cmd_err), 32'(x_err));
        acc = cmd_valid && r && rst_n;
        @(posedge clk);
        e++;
        m_update(acc);
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        bit a;
        cmd_valid = 0;
        for (int i = 0; i < n; i++) step(a);
    endtask

    task automatic issue(input logic [3:0] c, input int b, input int row, input int col,
                         output int acc_e, output int waits);
        bit a;
        cmd_valid = 1; cmd = c;
        addr_in = {b[1:0], row[11:0], col[7:0]};
        waits = 0; acc_e = -1;
        for (int n = 0; n < 200; n++) begin
            step(a);
            if (a) begin acc_e = e; break; end
            waits++;
        end
        chk("issue_accepted", 32'(acc_e >= 0), 32'd1);
        cmd_valid = 0;
    endtask

    task automatic present_stalled(input logic [3:0] c, input int b, input int n, input string tag);
        bit a;
        cmd_valid = 1; cmd = c; addr_in = {b[1:0], 20'h0};
        for (int i = 0; i < n; i++) begin
            step(a);
            chk(tag, 32'(obs_rdy), 32'd0);
        end
        cmd_valid = 0;
    endtask

    initial begin
        int ea, eb, w;
        logic [3:0] bo;
        bit a;
        e = 0;
        m_reset();
        rst_n = 0; cmd_valid = 0; cmd = 0; addr_in = 0; mrs = 0; dqm_in = 4'hA;
        @(posedge clk);
        @(negedge clk);
        idle(2);
        chk("rst_pins", 32'({cke, cs_n, ras_n, cas_n, we_n}), 32'h1F);
        chk("rst_dqm", 32'(dqm), 32'hF);
        chk("rst_ready", 32'(obs_rdy), 32'd0);
        rst_n = 1;
        idle(2);

        // 1: ACT then READ on bank 1
        issue(C_ACT, 1, 'h123, 0, ea, w);
        chk("t1_act_addr", 32'(addr), 32'h123);
        issue(C_READ, 1, 0, 'h45, eb, w);
        chk("t1_wait", 32'(w), 32'd1);
        chk("t1_gap", 32'(eb - ea), 32'd2);
        chk("t1_ba", 32'(ba), 32'd1);
        chk("t1_addr", 32'(addr), 32'h045);
        chk("t1_dqm", 32'(dqm), 32'hA);

        // 2: WRITA bank 0 then ACT bank 0
        issue(C_ACT, 0, 'h55, 0, ea, w);
        idle(6);
        issue(C_WRITA, 0, 0, 'h10, ea, w);
        chk("t2_addr", 32'(addr), 32'h410);
        chk("t2_pins", 32'({cs_n, ras_n, cas_n, we_n}), 32'h4);
        chk("t2_closed", 32'(bank_open[0]), 32'd0);
        issue(C_ACT, 0, 'h66, 0, eb, w);
        chk("t2_gap", 32'(eb - ea), 32'(T_WR + T_RP));

        // 3: REF stalls with bank 2 open; PALL then REF then ACT
        issue(C_ACT, 2, 'h3AB, 0, ea, w);
        present_stalled(C_REF, 0, 3, "t3_ref_stall");
        issue(C_PALL, 0, 0, 0, ea, w);
        issue(C_REF, 0, 0, 0, eb, w);
        chk("t3_ref_gap", 32'(eb - ea), 32'(T_RP));
        chk("t3_ref_pins", 32'({cs_n, ras_n, cas_n, we_n}), 32'h1);
        issue(C_ACT, 3, 'h7, 0, ea, w);
        chk("t3_act_gap", 32'(ea - eb), 32'(T_RFC));

        // 4: READ to closed bank 3
        issue(C_PRE, 3, 0, 0, ea, w);
        bo = bank_open;
        issue(C_READ, 3, 0, 5, ea, w);
        chk("t4_wait", 32'(w), 32'd0);
        chk("t4_err", 32'(cmd_err), 32'd1);
        chk("t4_pins", 32'({cs_n, ras_n, cas_n, we_n}), 32'h7);
        chk("t4_open", 32'(bank_open), 32'(bo));
        idle(1);
        chk("t4_err_pulse", 32'(cmd_err), 32'd0);

        // 5: self refresh, stall, recover
        issue(C_SELF, 0, 0, 0, ea, w);
        chk("t5_cke_low", 32'(cke), 32'd0);
        present_stalled(C_ACT, 0, 20, "t5_lp_stall");
        issue(C_REC, 0, 0, 0, ea, w);
        chk("t5_cke_high", 32'(cke), 32'd1);
        issue(C_ACT, 0, 'h11, 0, eb, w);
        chk("t5_gap", 32'(eb - ea), 32'(T_RC));

        // 6: reset during tRCD
        issue(C_PRE, 0, 0, 0, ea, w);
        issue(C_ACT, 0, 'h22, 0, ea, w);
        cmd_valid = 1; cmd = C_READ; addr_in = 22'h0;
        rst_n = 0;
        step(a);
        chk("t6_pins", 32'({cke, cs_n, ras_n, cas_n, we_n}), 32'h1F);
        chk("t6_open", 32'(bank_open), 32'd0);
        chk("t6_addr", 32'(addr), 32'd0);
        step(a);
        chk("t6_ready", 32'(obs_rdy), 32'd0);
        cmd_valid = 0;
        rst_n = 1;
        idle(2);

        // Random traffic
        for (int n = 0; n < 3000; n++) begin
            rst_n     = ($urandom_range(0, 299) != 0);
            cmd_valid = ($urandom_range(0, 3) != 0);
            cmd       = 4'($urandom_range(0, 15));
            addr_in   = 22'($urandom);
            mrs       = 12'($urandom);
            dqm_in    = 4'($urandom);
            step(a);
        end
        rst_n = 1;
        idle(2);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
